// File: rtl/release_memory.sv
// release_memory: frees a 32-word block by clearing the used bit in its header word.
// Optional RELEASE_MEMORY_SCRUB_EN also zeroes the block payload after the header write.
module release_memory #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 32,
  parameter int USED_BIT    = 31
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  free_req,
  input  logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  output logic [15:0]           free_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  localparam int OW = $clog2(BLOCK_WORDS);
`ifdef RELEASE_MEMORY_SCRUB_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WRITE, SCRUB, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WRITE, DONE} state_t;
`endif
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            err_q, err_d;
  logic [15:0]           free_count_q;
  logic                  bad_addr;
`ifdef RELEASE_MEMORY_SCRUB_EN
  logic [OW-1:0]         cnt_q, cnt_d;
`endif
  assign bad_addr   = (addr_q == '0) || (addr_q[OW-1:0] != '0);
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign free_count = free_count_q;
  // State, latched request and captured header; reset aborts any free in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 2'b00;
      free_count_q <= '0;
`ifdef RELEASE_MEMORY_SCRUB_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      free_count_q <= (done && err_q == 2'b00 && free_count_q != 16'hFFFF) ? free_count_q + 16'd1 : free_count_q;
`ifdef RELEASE_MEMORY_SCRUB_EN
      cnt_q        <= cnt_d;
`endif
    end
  end
  // Next state and RAM port drive; the address check happens in READ so a bad request never touches RAM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = err_q;
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
`ifdef RELEASE_MEMORY_SCRUB_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: if (free_req) begin
        addr_d  = free_addr;
        err_d   = 2'b00;
        state_d = READ;
      end
      READ: begin
        mem_address = bad_addr ? '0 : addr_q;
        err_d       = bad_addr ? 2'b10 : 2'b00;
        state_d     = bad_addr ? DONE : WAIT;
      end
      WAIT: begin
        mem_address = addr_q;
        state_d     = CHECK;
      end
      CHECK: begin
        mem_address      = addr_q;
        data_d           = mem_q;
        data_d[USED_BIT] = 1'b0;
        err_d            = mem_q[USED_BIT] ? 2'b00 : 2'b01;
        state_d          = mem_q[USED_BIT] ? WRITE : DONE;
      end
      WRITE: begin
        mem_address = addr_q;
        mem_data    = data_q;
        mem_wren    = 1'b1;
`ifdef RELEASE_MEMORY_SCRUB_EN
        cnt_d       = OW'(1);
        state_d     = SCRUB;
`else
        state_d     = DONE;
`endif
      end
`ifdef RELEASE_MEMORY_SCRUB_EN
      SCRUB: begin
        mem_address = addr_q | ADDR_WIDTH'(cnt_q);
        mem_wren    = 1'b1;
        cnt_d       = cnt_q + OW'(1);
        state_d     = (cnt_q == '1) ? DONE : SCRUB;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_release_memory.sv
// tb_release_memory: randomized and directed checks of release_memory against a block-level model.
module tb_release_memory;
`ifdef RELEASE_MEMORY_SCRUB_EN
  localparam int SCRUB = 1;
`else
  localparam int SCRUB = 0;
`endif
  logic        clock = 0, resetn = 0, free_req = 0;
  logic [9:0]  free_addr = '0;
  logic        busy, done, mem_wren;
  logic [1:0]  err;
  logic [15:0] free_count;
  logic [9:0]  mem_address, a1;
  logic [31:0] mem_data, mem_q;
  logic [31:0] ram [1024] = '{default: 32'h0};
  logic [31:0] exp_ram [1024] = '{default: 32'h0};
  logic        pk_en = 0;
  logic [9:0]  pk_a = '0;
  logic [31:0] pk_d = '0;
  int          wr_cnt = 0, total = 0, bad = 0, exp_fc = 0;

  release_memory dut (
    .clock(clock), .resetn(resetn), .free_req(free_req), .free_addr(free_addr),
    .busy(busy), .done(done), .err(err), .free_count(free_count),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM with two-cycle read latency, plus a bench-side preload port.
  always @(posedge clock) begin
    if (pk_en) ram[pk_a] <= pk_d;
    else if (mem_wren) ram[mem_address] <= mem_data;
    a1    <= mem_address;
    mem_q <= ram[a1];
  end

  // Count every RAM write cycle.
  always @(posedge clock) if (mem_wren) wr_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    pk_a = a; pk_d = d; pk_en = 1;
    @(negedge clock);
    pk_en = 0;
    exp_ram[a] = d;
  endtask

  function automatic int block_mismatches(input logic [9:0] a);
    int mm = 0;
    int base = int'(a) & 32'h3E0;
    for (int i = 0; i <= 32; i++) if (ram[(base + i) % 1024] !== exp_ram[(base + i) % 1024]) mm++;
    return mm;
  endfunction

  task automatic run(input logic [9:0] a, input string tag);
    int lat, w0, e_lat, e_wr;
    logic [1:0] e_err;
    logic isbad = (a == 0) || (a % 32 != 0);
    e_err = isbad ? 2'b10 : (exp_ram[a][31] ? 2'b00 : 2'b01);
    e_lat = isbad ? 2 : (e_err == 2'b01 ? 4 : 5 + SCRUB * 31);
    e_wr  = (e_err == 2'b00) ? 1 + SCRUB * 31 : 0;
    if (e_err == 2'b00) begin
      exp_ram[a][31] = 1'b0;
      if (SCRUB == 1) for (int i = 1; i < 32; i++) exp_ram[a + 10'(i)] = 32'h0;
      if (exp_fc < 65535) exp_fc++;
    end
    w0 = wr_cnt;
    @(negedge clock);
    free_addr = a; free_req = 1;
    @(posedge clock); #1;
    free_req = 0;
    chk({tag, "_busy_start"}, busy, 1);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_err"}, err, e_err);
    @(posedge clock); #1;
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_free_count"}, free_count, exp_fc);
    chk({tag, "_writes"}, wr_cnt - w0, e_wr);
    chk({tag, "_ram"}, block_mismatches(a), 0);
  endtask

  initial begin
    int w0, n;
    logic [9:0] a;
    logic [31:0] d;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", free_count, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    @(negedge clock);
    resetn = 1;
    poke(10'd192, 32'h8000_0001);
    run(10'd192, "pre");
    // Asynchronous reset while the header write is being driven.
    poke(10'd64, 32'h8000_1234);
    w0 = wr_cnt;
    @(negedge clock);
    free_addr = 10'd64; free_req = 1;
    @(posedge clock); #1;
    free_req = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_wren_in_write", mem_wren, 1);
    chk("mid_data_in_write", mem_data, 32'h0000_1234);
    #1 resetn = 0;
    #1;
    chk("mid_rst_wren", mem_wren, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_count", free_count, 0);
    chk("mid_rst_addr", mem_address, 0);
    chk("mid_rst_data", mem_data, 0);
    exp_fc = 0;
    @(posedge clock); #1;
    chk("mid_no_write", ram[64], 32'h8000_1234);
    chk("mid_writes", wr_cnt - w0, 0);
    @(negedge clock);
    resetn = 1;
    run(10'd64, "ok64");
    chk("ok64_word", ram[64], 32'h0000_1234);
    poke(10'd96, 32'h0000_0005);
    run(10'd96, "dbl96");
    run(10'd0, "bad0");
    run(10'd70, "bad70");
    for (int i = 128; i < 160; i++) poke(10'(i), 32'hFFFF_FFFF);
    poke(10'd160, 32'hA5A5_5A5A);
    run(10'd128, "blk128");
    chk("blk128_header", ram[128], 32'h7FFF_FFFF);
    chk("blk128_next", ram[160], 32'hA5A5_5A5A);
    // Request held high across the whole free: exactly one successful free.
    poke(10'd64, 32'h8000_1234);
    w0 = wr_cnt;
    exp_fc++;
    exp_ram[64] = 32'h0000_1234;
    if (SCRUB == 1) for (int i = 65; i < 96; i++) exp_ram[i] = 32'h0;
    @(negedge clock);
    free_addr = 10'd64; free_req = 1;
    repeat (10) @(negedge clock);
    free_req = 0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("hold_idle", busy, 0);
    chk("hold_count", free_count, exp_fc);
    chk("hold_writes", wr_cnt - w0, 1 + SCRUB * 31);
    chk("hold_ram", block_mismatches(10'd64), 0);
    run(10'd64, "hold_again");
    for (int k = 0; k < 12; k++) begin
      a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 31) * 32) : 10'($urandom_range(0, 1023));
      if (a != 0 && a % 32 == 0) begin
        d = $urandom;
        d[31] = 1'($urandom_range(0, 1));
        poke(a, d);
        poke(a + 10'd7, $urandom | 32'h1);
      end
      run(a, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
